// File: rtl/queue_controller.sv
// Queue occupancy tracker and wait-time LUT sequencer: counts sensor edges,
// issues pCount/tCount to a negedge-registered LUT and captures its result.
module queue_controller #(
  parameter int unsigned MAX_COUNT    = 7,
  parameter logic [4:0]  CLOSED_WTIME = 5'd31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic       leave,
  input  logic [1:0] tellers,
  input  logic [4:0] lut_wTime,
  output logic [2:0] lut_pCount,
  output logic [1:0] lut_tCount,
  output logic [2:0] pCount,
  output logic [4:0] wTime,
  output logic       wTime_valid,
  output logic       full,
  output logic       empty,
  output logic       ovf,
  output logic       unf,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  localparam logic [2:0] MAX_C = 3'(MAX_COUNT);

  state_t     r_state;
  logic       r_enter_d;
  logic       r_leave_d;
  logic [1:0] r_tellers_d;
  logic [2:0] r_pcount;
  logic       r_ovf;
  logic       r_unf;
  logic       r_pending;
  logic [2:0] r_snap_p;
  logic [1:0] r_snap_t;
  logic [2:0] r_lut_p;
  logic [1:0] r_lut_t;
  logic [4:0] r_wtime;
  logic       r_wtime_valid;

  logic       w_enter_edge;
  logic       w_leave_edge;
  logic [2:0] w_pcount_next;
  logic       w_set_ovf;
  logic       w_set_unf;
  logic       w_change;
  logic       w_start;
  logic [4:0] w_capture_wtime;

  assign w_enter_edge = enter & ~r_enter_d;
  assign w_leave_edge = leave & ~r_leave_d;

  // Simultaneous entry and exit cancel out without touching the flags.
  always_comb begin
    w_pcount_next = r_pcount;
    w_set_ovf     = 1'b0;
    w_set_unf     = 1'b0;
    if (w_enter_edge && !w_leave_edge) begin
      if (r_pcount < MAX_C) w_pcount_next = r_pcount + 3'd1;
      else                  w_set_ovf     = 1'b1;
    end else if (w_leave_edge && !w_enter_edge) begin
      if (r_pcount != 3'd0) w_pcount_next = r_pcount - 3'd1;
      else                  w_set_unf     = 1'b1;
    end
  end

  assign w_change = (w_pcount_next != r_pcount) || (tellers != r_tellers_d);
  assign w_start  = (r_state == S_IDLE) && r_pending;

  always_comb begin
    w_capture_wtime = lut_wTime;
    if (r_snap_t == 2'd0)      w_capture_wtime = CLOSED_WTIME;
    else if (r_snap_p == 3'd0) w_capture_wtime = 5'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_enter_d     <= 1'b0;
      r_leave_d     <= 1'b0;
      // Tracks tellers through reset so the forced first lookup is not followed by a spurious one.
      r_tellers_d   <= tellers;
      r_pcount      <= 3'd0;
      r_ovf         <= 1'b0;
      r_unf         <= 1'b0;
      r_pending     <= 1'b1;
      r_snap_p      <= 3'd0;
      r_snap_t      <= 2'd0;
      r_lut_p       <= 3'd0;
      r_lut_t       <= 2'd1;
      r_wtime       <= 5'd0;
      r_wtime_valid <= 1'b0;
    end else begin
      r_enter_d     <= enter;
      r_leave_d     <= leave;
      r_tellers_d   <= tellers;
      r_pcount      <= w_pcount_next;
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
      // A change in the cycle the FSM leaves IDLE re-arms pending.
      r_pending     <= w_change | (r_pending & ~w_start);
      r_wtime_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            r_snap_p <= r_pcount;
            r_snap_t <= tellers;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_snap_t == 2'd0) begin
            r_state <= S_CAPTURE;
          end else begin
            r_lut_p <= r_snap_p;
            r_lut_t <= r_snap_t;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_wtime       <= w_capture_wtime;
          r_wtime_valid <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lut_pCount  = r_lut_p;
  assign lut_tCount  = r_lut_t;
  assign pCount      = r_pcount;
  assign wTime       = r_wtime;
  assign wTime_valid = r_wtime_valid;
  assign full        = (r_pcount == MAX_C);
  assign empty       = (r_pcount == 3'd0);
  assign ovf         = r_ovf;
  assign unf         = r_unf;
  assign dbg_state   = r_state;

endmodule
